// File: rtl/windowed_watchdog.sv
// Windowed watchdog: NUM_CH independent channels, each of which must be kicked
// inside the window [WIN_OPEN, MAX_COUNT-1] of its cycle counter. A kick that
// comes too early, or no kick before the counter runs out, latches the channel
// in EXPIRED until it is cleared.
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   en[ch]       channel enable
//   flag[ch]     channel kick
//   clr[ch]      clear of an expired channel
//   warn[ch]     counter is in the late part of the open window
//   interrupt[ch] sticky timeout / violation
//   early_err[ch] sticky early-kick indication
//   sys_rst_req  OR of all interrupts, one cycle late
module windowed_watchdog #(
    parameter int NUM_CH     = 2,
    parameter int MAX_COUNT  = 100,
    parameter int WIN_OPEN   = 20,
    parameter int WARN_COUNT = 80
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] flag,
    input  logic [NUM_CH-1:0] clr,
    output logic [NUM_CH-1:0] warn,
    output logic [NUM_CH-1:0] interrupt,
    output logic [NUM_CH-1:0] early_err,
    output logic              sys_rst_req
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

    // Compare values are one below the threshold because decisions are taken
    // on the cycle before the counter reaches it.
    localparam logic [CNT_W-1:0] CNT_OPEN_M1 = CNT_W'(WIN_OPEN - 1);
    localparam logic [CNT_W-1:0] CNT_WARN_M1 = CNT_W'(WARN_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(MAX_COUNT - 1);

    // Elaboration-time parameter sanity check.
    if (!(WIN_OPEN > 0 && WIN_OPEN < WARN_COUNT && WARN_COUNT < MAX_COUNT && NUM_CH >= 1))
    begin : g_bad_params
        $fatal(1, "windowed_watchdog: need 0 < WIN_OPEN < WARN_COUNT < MAX_COUNT and NUM_CH >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLOSED,
        S_OPEN,
        S_EXPIRED
    } state_t;

    state_t            r_state [NUM_CH];
    logic [CNT_W-1:0]  r_cnt   [NUM_CH];
    logic [NUM_CH-1:0] r_warn;
    logic [NUM_CH-1:0] r_int;
    logic [NUM_CH-1:0] r_early;
    logic              r_sys;

    // Per-channel FSM, counter and registered flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            r_warn  <= '0;
            r_int   <= '0;
            r_early <= '0;
            r_sys   <= 1'b0;
        end else begin
            r_sys <= |r_int;
            for (int i = 0; i < NUM_CH; i++) begin
                // warn only stays up on an uneventful OPEN cycle
                r_warn[i] <= 1'b0;
                case (r_state[i])
                    S_IDLE: begin
                        r_cnt[i] <= '0;
                        if (en[i]) r_state[i] <= S_CLOSED;
                    end
                    S_CLOSED: begin
                        if (!en[i]) begin
                            r_state[i] <= S_IDLE;
                            r_cnt[i]   <= '0;
                        end else if (flag[i]) begin
                            r_state[i] <= S_EXPIRED;
                            r_int[i]   <= 1'b1;
                            r_early[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                            if (r_cnt[i] == CNT_OPEN_M1) r_state[i] <= S_OPEN;
                        end
                    end
                    S_OPEN: begin
                        if (!en[i]) begin
                            r_state[i] <= S_IDLE;
                            r_cnt[i]   <= '0;
                        end else if (flag[i]) begin
                            // a kick on the last count still services the channel
                            r_state[i] <= S_CLOSED;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i] <= S_EXPIRED;
                            r_int[i]   <= 1'b1;
                        end else begin
                            r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
                            r_warn[i] <= (r_cnt[i] >= CNT_WARN_M1);
                        end
                    end
                    S_EXPIRED: begin
                        // counter frozen; flag and en ignored until cleared
                        if (clr[i]) begin
                            r_int[i]   <= 1'b0;
                            r_early[i] <= 1'b0;
                            r_cnt[i]   <= '0;
                            r_state[i] <= en[i] ? S_CLOSED : S_IDLE;
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign warn        = r_warn;
    assign interrupt   = r_int;
    assign early_err   = r_early;
    assign sys_rst_req = r_sys;

endmodule

// File: tb/tb_windowed_watchdog.sv
// Testbench for windowed_watchdog: directed scenarios plus randomized traffic.
// Every driven cycle pushes the reference model's expected outputs into a
// queue; a monitor pops one entry after each rising edge and compares.
module tb_windowed_watchdog;

    localparam int NCH   = 2;
    localparam int MAXC  = 100;
    localparam int WOPEN = 20;
    localparam int WARNC = 80;

    logic           clk  = 1'b0;
    logic           rstn = 1'b1;
    logic [NCH-1:0] en   = '0;
    logic [NCH-1:0] flag = '0;
    logic [NCH-1:0] clr  = '0;
    logic [NCH-1:0] warn;
    logic [NCH-1:0] interrupt;
    logic [NCH-1:0] early_err;
    logic           sys_rst_req;

    windowed_watchdog #(
        .NUM_CH    (NCH),
        .MAX_COUNT (MAXC),
        .WIN_OPEN  (WOPEN),
        .WARN_COUNT(WARNC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .flag       (flag),
        .clr        (clr),
        .warn       (warn),
        .interrupt  (interrupt),
        .early_err  (early_err),
        .sys_rst_req(sys_rst_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] warn;
        logic [NCH-1:0] intr;
        logic [NCH-1:0] early;
        logic           sys;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a channel is either off, running with an age (cycles
    // since it was started or last serviced), or tripped.
    bit m_active [NCH];
    bit m_trip   [NCH];
    bit m_early  [NCH];
    int m_age    [NCH];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_active[i] = 1'b0;
            m_trip[i]   = 1'b0;
            m_early[i]  = 1'b0;
            m_age[i]    = 0;
        end
    endfunction

    // Advance the model over one rising edge; return outputs seen after it.
    function automatic exp_t model_step(input logic [NCH-1:0] e, input logic [NCH-1:0] f,
                                        input logic [NCH-1:0] c);
        exp_t r;
        logic prev_any;
        prev_any = 1'b0;
        for (int i = 0; i < NCH; i++) prev_any = prev_any | m_trip[i];
        for (int i = 0; i < NCH; i++) begin
            if (m_trip[i]) begin
                if (c[i]) begin
                    m_trip[i]   = 1'b0;
                    m_early[i]  = 1'b0;
                    m_age[i]    = 0;
                    m_active[i] = e[i];
                end
            end else if (!m_active[i]) begin
                if (e[i]) begin
                    m_active[i] = 1'b1;
                    m_age[i]    = 0;
                end
            end else if (!e[i]) begin
                m_active[i] = 1'b0;
                m_age[i]    = 0;
            end else if (f[i]) begin
                if (m_age[i] < WOPEN) begin
                    m_trip[i]  = 1'b1;
                    m_early[i] = 1'b1;
                end else begin
                    m_age[i] = 0;
                end
            end else if (m_age[i] == MAXC - 1) begin
                m_trip[i] = 1'b1;
            end else begin
                m_age[i] = m_age[i] + 1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            r.warn[i]  = m_active[i] && !m_trip[i] && (m_age[i] >= WARNC);
            r.intr[i]  = m_trip[i];
            r.early[i] = m_early[i];
        end
        r.sys = prev_any;
        return r;
    endfunction

    // One clock of stimulus, called and returning at a falling edge.
    task automatic cyc(input logic [NCH-1:0] e, input logic [NCH-1:0] f, input logic [NCH-1:0] c);
        en   = e;
        flag = f;
        clr  = c;
        q.push_back(model_step(e, f, c));
        @(negedge clk);
    endtask

    function automatic bit running_at(input int ch, input int age);
        return m_active[ch] && !m_trip[ch] && (m_age[ch] == age);
    endfunction

    // Idle cycles with enable e until channel ch sits at the given count.
    task automatic run_to_age(input int ch, input int age, input logic [NCH-1:0] e);
        int guard;
        guard = 0;
        while (!running_at(ch, age) && guard < 1000) begin
            cyc(e, '0, '0);
            guard++;
        end
        check("reach_age", 32'(guard < 1000), 32'd1);
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("warn",        32'(warn),        32'(x.warn));
                check("interrupt",   32'(interrupt),   32'(x.intr));
                check("early_err",   32'(early_err),   32'(x.early));
                check("sys_rst_req", 32'(sys_rst_req), 32'(x.sys));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not finish, got hang, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int tgt [NCH];
        logic [NCH-1:0] e, f, c;

        model_reset();
        #2 rstn = 1'b0;
        #1;
        check("rst_warn", 32'(warn), 32'd0);
        check("rst_int",  32'(interrupt), 32'd0);
        check("rst_early", 32'(early_err), 32'd0);
        check("rst_sys",  32'(sys_rst_req), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // No-kick timeout on ch0.
        for (int n = 1; n <= 102; n++) begin
            cyc(2'b01, '0, '0);
            if (n == 80)  check("t_warn_c79", 32'(warn[0]), 32'd0);
            if (n == 81)  check("t_warn_c80", 32'(warn[0]), 32'd1);
            if (n == 100) check("t_warn_c99", 32'(warn[0]), 32'd1);
            if (n == 101) begin
                check("t_int_c100",  32'(interrupt), 32'b01);
                check("t_warn_c100", 32'(warn[0]), 32'd0);
                check("t_sys_c100",  32'(sys_rst_req), 32'd0);
            end
            if (n == 102) check("t_sys_c101", 32'(sys_rst_req), 32'd1);
        end
        cyc(2'b00, '0, 2'b01);
        cyc(2'b00, '0, '0);

        // Periodic servicing at count 50.
        for (int n = 0; n < 400; n++)
            cyc(2'b01, running_at(0, 50) ? 2'b01 : 2'b00, '0);
        cyc(2'b00, '0, '0);

        // Early kick, ignored later kicks, clear.
        run_to_age(0, 10, 2'b01);
        cyc(2'b01, 2'b01, '0);
        check("early_err_set", 32'(early_err[0]), 32'd1);
        check("early_int_set", 32'(interrupt[0]), 32'd1);
        repeat (3) cyc(2'b01, 2'b01, '0);
        cyc(2'b01, '0, 2'b01);
        check("early_cleared", 32'({early_err[0], interrupt[0]}), 32'd0);
        run_to_age(0, 30, 2'b01);
        cyc(2'b01, 2'b01, '0);
        cyc(2'b00, '0, '0);

        // Kick on the last count, then clr with flag in EXPIRED.
        run_to_age(0, 99, 2'b01);
        cyc(2'b01, 2'b01, '0);
        check("kick99_no_int", 32'(interrupt[0]), 32'd0);
        repeat (101) cyc(2'b01, '0, '0);
        cyc(2'b01, 2'b01, 2'b01);
        check("clrflag_early", 32'(early_err[0]), 32'd0);
        check("clrflag_int",   32'(interrupt[0]), 32'd0);
        run_to_age(0, 20, 2'b01);
        cyc(2'b01, 2'b01, '0);
        cyc(2'b00, '0, '0);

        // Enable drop at count 60 (with a kick), then ch1 expires and is reset mid-cycle.
        run_to_age(0, 60, 2'b01);
        cyc(2'b00, 2'b01, '0);
        repeat (120) cyc(2'b10, '0, '0);
        check("ch1_expired", 32'(interrupt), 32'b10);
        #2 rstn = 1'b0;
        #1;
        check("async_warn",  32'(warn), 32'd0);
        check("async_int",   32'(interrupt), 32'd0);
        check("async_early", 32'(early_err), 32'd0);
        check("async_sys",   32'(sys_rst_req), 32'd0);
        @(negedge clk);
        en   = '0;
        rstn = 1'b1;
        model_reset();
        q.delete();

        // Independence: ch0 serviced at 40, ch1 left to time out.
        for (int n = 1; n <= 102; n++) begin
            cyc(2'b11, running_at(0, 40) ? 2'b01 : 2'b00, '0);
            if (n == 100) check("ind_int_c99",  32'(interrupt), 32'b00);
            if (n == 101) check("ind_int_c100", 32'(interrupt), 32'b10);
            if (n == 102) check("ind_sys_c101", 32'(sys_rst_req), 32'd1);
        end
        cyc(2'b00, '0, 2'b11);

        // Randomized traffic.
        for (int i = 0; i < NCH; i++) tgt[i] = $urandom_range(110, 5);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                e[i] = ($urandom_range(299, 0) != 0);
                f[i] = running_at(i, tgt[i]) || ($urandom_range(99, 0) == 0);
                if (running_at(i, tgt[i])) tgt[i] = $urandom_range(110, 5);
                c[i] = m_trip[i] ? ($urandom_range(7, 0) == 0) : ($urandom_range(39, 0) == 0);
            end
            cyc(e, f, c);
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
